boot_loader: RTL and testbench

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/boot_pkg.sv | 15 +
 rtl/boot_loader.sv | 109 ++++++++++
 tb/tb_boot_loader.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared types and widths for the boot loader.
package boot_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StWaitLen,
    StLoad,
    StCommit,
    StRun
  } state_e;

endpackage

// File: rtl/boot_loader.sv
// Byte-stream boot loader: receives a length byte followed by that many data
// bytes, writes them to memory from address 0 while holding the CPU in reset,
// then hands the memory port to the CPU.
module boot_loader
  import boot_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              loadReq,
  input  logic [DATA_W-1:0] rxData,
  input  logic              rxValid,
  output logic              rxReady,
  input  logic              cpuMemEnable,
  input  logic [ADDR_W-1:0] cpuMemAdr,
  input  logic [DATA_W-1:0] cpuMemWD,
  output logic              memEnable,
  output logic [ADDR_W-1:0] memAdr,
  output logic [DATA_W-1:0] memWD,
  output logic              cpuReset,
  output logic              done
);

  localparam logic [ADDR_W-1:0] AdrOne = ADDR_W'(1);

  state_e            state_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_adr_q;
  logic [DATA_W-1:0] wr_wd_q;
  logic              done_q;

  logic              rx_hs;
  logic              last_byte;
  logic [ADDR_W-1:0] len_m1;

  // Handshake and last-byte detection; len = 0 wraps to 255, i.e. 256 bytes.
  assign rxReady   = (state_q == StWaitLen) || (state_q == StLoad);
  assign rx_hs     = rxValid & rxReady;
  assign len_m1    = len_q - AdrOne;
  assign last_byte = (cnt_q == len_m1);
  assign cpuReset  = (state_q != StRun);
  assign done      = done_q;

  // Loader FSM with counter, length and registered write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      len_q    <= '0;
      cnt_q    <= '0;
      wr_en_q  <= 1'b0;
      wr_adr_q <= '0;
      wr_wd_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      // Write enable and done are single-cycle pulses.
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          state_q <= StWaitLen;
        end
        StWaitLen: begin
          if (rx_hs) begin
            len_q   <= rxData;
            cnt_q   <= '0;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          if (rx_hs) begin
            wr_en_q  <= 1'b1;
            wr_adr_q <= cnt_q;
            wr_wd_q  <= rxData;
            cnt_q    <= cnt_q + AdrOne;
            if (last_byte) begin
              state_q <= StCommit;
            end
          end
        end
        StCommit: begin
          state_q <= StRun;
          done_q  <= 1'b1;
        end
        StRun: begin
          if (loadReq) begin
            state_q <= StWaitLen;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Memory port mux: CPU owns the port only in RUN.
  always_comb begin
    memEnable = wr_en_q;
    memAdr    = wr_adr_q;
    memWD     = wr_wd_q;
    if (state_q == StRun) begin
      memEnable = cpuMemEnable;
      memAdr    = cpuMemAdr;
      memWD     = cpuMemWD;
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Directed self-checking bench for boot_loader.
module tb_boot_loader;

  logic       clk;
  logic       reset;
  logic       loadReq;
  logic [7:0] rxData;
  logic       rxValid;
  logic       rxReady;
  logic       cpuMemEnable;
  logic [7:0] cpuMemAdr;
  logic [7:0] cpuMemWD;
  logic       memEnable;
  logic [7:0] memAdr;
  logic [7:0] memWD;
  logic       cpuReset;
  logic       done;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int done_cnt = 0;

  boot_loader dut (
    .clk          (clk),
    .reset        (reset),
    .loadReq      (loadReq),
    .rxData       (rxData),
    .rxValid      (rxValid),
    .rxReady      (rxReady),
    .cpuMemEnable (cpuMemEnable),
    .cpuMemAdr    (cpuMemAdr),
    .cpuMemWD     (cpuMemWD),
    .memEnable    (memEnable),
    .memAdr       (memAdr),
    .memWD        (memWD),
    .cpuReset     (cpuReset),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts loader writes and done pulses, sampled mid low phase.
  always @(negedge clk) begin
    #2;
    if (reset && cpuReset && memEnable) wr_cnt <= wr_cnt + 1;
    if (reset && done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic pulse_load();
    loadReq = 1'b1;
    @(negedge clk);
    loadReq = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; loadReq = 1'b0; rxData = 8'h00; rxValid = 1'b0;
    cpuMemEnable = 1'b0; cpuMemAdr = 8'h00; cpuMemWD = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if ({cpuReset, memEnable, memAdr, memWD, rxReady, done} !== {1'b1, 1'b0, 8'h00, 8'h00, 2'b00})
    begin
      errors++;
      $display("FAIL reset_outputs got %b_%b_%h_%h_%b_%b exp 1_0_00_00_0_0",
               cpuReset, memEnable, memAdr, memWD, rxReady, done);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({rxReady, cpuReset} !== 2'b01) begin
      errors++;
      $display("FAIL reset_idle got rxReady=%b cpuReset=%b exp 0 1", rxReady, cpuReset);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({rxReady, cpuReset, memEnable} !== 3'b110) begin
        errors++;
        $display("FAIL reset_waitlen%0d got rxReady=%b cpuReset=%b memEnable=%b exp 1 1 0",
                 i, rxReady, cpuReset, memEnable);
      end
    end
  endtask

  task automatic test_stream();
    logic [7:0] bytes [4];
    int wr0;
    int d0;
    bytes[0] = 8'h03; bytes[1] = 8'hAA; bytes[2] = 8'hBB; bytes[3] = 8'hCC;
    wr0 = wr_cnt;
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) begin
      rxData = bytes[i];
      rxValid = 1'b1;
      @(negedge clk);
      checks++;
      if (i == 0) begin
        if ({memEnable, cpuReset} !== 2'b01) begin
          errors++;
          $display("FAIL stream_len got memEnable=%b cpuReset=%b exp 0 1", memEnable, cpuReset);
        end
      end else if ({memEnable, memAdr, memWD, cpuReset} !== {1'b1, 8'(i - 1), bytes[i], 1'b1})
      begin
        errors++;
        $display("FAIL stream_wr%0d got %b %h %h cpuReset=%b exp 1 %h %h 1",
                 i, memEnable, memAdr, memWD, cpuReset, 8'(i - 1), bytes[i]);
      end
    end
    rxData = 8'hDD;
    checks++;
    if (rxReady !== 1'b0) begin
      errors++;
      $display("FAIL stream_commit_rxready got %b exp 0", rxReady);
    end
    @(negedge clk);
    checks++;
    if ({done, cpuReset, rxReady, memEnable} !== 4'b1000) begin
      errors++;
      $display("FAIL stream_run got done=%b cpuReset=%b rxReady=%b memEnable=%b exp 1 0 0 0",
               done, cpuReset, rxReady, memEnable);
    end
    @(negedge clk);
    rxValid = 1'b0;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL stream_done_pulse got %b exp 0", done);
    end
    @(negedge clk);
    checks++;
    if ((wr_cnt - wr0) != 3 || (done_cnt - d0) != 1) begin
      errors++;
      $display("FAIL stream_counts got writes=%0d dones=%0d exp 3 1", wr_cnt - wr0, done_cnt - d0);
    end
  endtask

  task automatic test_len256();
    int wr0;
    pulse_load();
    checks++;
    if ({rxReady, cpuReset} !== 2'b11) begin
      errors++;
      $display("FAIL l256_reload got rxReady=%b cpuReset=%b exp 1 1", rxReady, cpuReset);
    end
    wr0 = wr_cnt;
    rxData = 8'h00;
    rxValid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      rxData = 8'(i);
      @(negedge clk);
      checks++;
      if ({memEnable, memAdr, memWD} !== {1'b1, 8'(i), 8'(i)}) begin
        errors++;
        $display("FAIL l256_wr%0d got %b %h %h exp 1 %h %h", i, memEnable, memAdr, memWD,
                 8'(i), 8'(i));
      end
    end
    rxData = 8'h99;
    checks++;
    if (rxReady !== 1'b0) begin
      errors++;
      $display("FAIL l256_no_257th got rxReady=%b exp 0", rxReady);
    end
    @(negedge clk);
    checks++;
    if ({done, cpuReset, memEnable} !== 3'b100) begin
      errors++;
      $display("FAIL l256_run got done=%b cpuReset=%b memEnable=%b exp 1 0 0",
               done, cpuReset, memEnable);
    end
    @(negedge clk);
    rxValid = 1'b0;
    @(negedge clk);
    checks++;
    if ((wr_cnt - wr0) != 256) begin
      errors++;
      $display("FAIL l256_count got %0d exp 256", wr_cnt - wr0);
    end
  endtask

  task automatic test_stall();
    int wr0;
    pulse_load();
    wr0 = wr_cnt;
    rxData = 8'h02;
    rxValid = 1'b1;
    @(negedge clk);
    rxData = 8'h11;
    @(negedge clk);
    checks++;
    if ({memEnable, memAdr, memWD} !== {1'b1, 8'h00, 8'h11}) begin
      errors++;
      $display("FAIL stall_wr0 got %b %h %h exp 1 00 11", memEnable, memAdr, memWD);
    end
    rxValid = 1'b0;
    rxData = 8'hEE;
    for (int g = 0; g < 5; g++) begin
      @(negedge clk);
      checks++;
      if ({memEnable, rxReady, cpuReset} !== 3'b011) begin
        errors++;
        $display("FAIL stall_gap%0d got memEnable=%b rxReady=%b cpuReset=%b exp 0 1 1",
                 g, memEnable, rxReady, cpuReset);
      end
    end
    rxData = 8'h22;
    rxValid = 1'b1;
    @(negedge clk);
    rxValid = 1'b0;
    checks++;
    if ({memEnable, memAdr, memWD} !== {1'b1, 8'h01, 8'h22}) begin
      errors++;
      $display("FAIL stall_wr1 got %b %h %h exp 1 01 22", memEnable, memAdr, memWD);
    end
    @(negedge clk);
    checks++;
    if ({done, cpuReset} !== 2'b10) begin
      errors++;
      $display("FAIL stall_run got done=%b cpuReset=%b exp 1 0", done, cpuReset);
    end
    @(negedge clk);
    checks++;
    if ((wr_cnt - wr0) != 2) begin
      errors++;
      $display("FAIL stall_count got %0d exp 2", wr_cnt - wr0);
    end
  endtask

  task automatic test_cpu_passthrough();
    cpuMemEnable = 1'b1;
    cpuMemAdr = 8'h5A;
    cpuMemWD = 8'h33;
    loadReq = 1'b1;
    #1;
    checks++;
    if ({memEnable, memAdr, memWD, cpuReset} !== {1'b1, 8'h5A, 8'h33, 1'b0}) begin
      errors++;
      $display("FAIL cpu_pass got %b %h %h cpuReset=%b exp 1 5a 33 0",
               memEnable, memAdr, memWD, cpuReset);
    end
    @(negedge clk);
    loadReq = 1'b0;
    checks++;
    if ({cpuReset, memEnable, rxReady} !== 3'b101) begin
      errors++;
      $display("FAIL cpu_reclaim got cpuReset=%b memEnable=%b rxReady=%b exp 1 0 1",
               cpuReset, memEnable, rxReady);
    end
    rxData = 8'h01;
    rxValid = 1'b1;
    @(negedge clk);
    rxData = 8'h77;
    @(negedge clk);
    rxValid = 1'b0;
    checks++;
    if ({memEnable, memAdr, memWD} !== {1'b1, 8'h00, 8'h77}) begin
      errors++;
      $display("FAIL cpu_reload_wr got %b %h %h exp 1 00 77", memEnable, memAdr, memWD);
    end
    @(negedge clk);
    checks++;
    if ({done, cpuReset, memEnable, memAdr, memWD} !== {2'b10, 1'b1, 8'h5A, 8'h33}) begin
      errors++;
      $display("FAIL cpu_reload_run got done=%b cpuReset=%b %b %h %h exp 1 0 1 5a 33",
               done, cpuReset, memEnable, memAdr, memWD);
    end
    cpuMemEnable = 1'b0;
    cpuMemAdr = 8'h00;
    cpuMemWD = 8'h00;
  endtask

  task automatic test_reset_abort();
    int wr0;
    pulse_load();
    rxData = 8'h04;
    rxValid = 1'b1;
    @(negedge clk);
    rxData = 8'hA1;
    @(negedge clk);
    checks++;
    if ({memEnable, memAdr, memWD} !== {1'b1, 8'h00, 8'hA1}) begin
      errors++;
      $display("FAIL abort_wr0 got %b %h %h exp 1 00 a1", memEnable, memAdr, memWD);
    end
    rxData = 8'hA2;
    @(negedge clk);
    checks++;
    if ({memEnable, memAdr, memWD} !== {1'b1, 8'h01, 8'hA2}) begin
      errors++;
      $display("FAIL abort_wr1 got %b %h %h exp 1 01 a2", memEnable, memAdr, memWD);
    end
    reset = 1'b0;
    rxData = 8'hA3;
    #1;
    wr0 = wr_cnt;
    checks++;
    if ({cpuReset, memEnable, memAdr, memWD, rxReady, done} !== {1'b1, 1'b0, 8'h00, 8'h00, 2'b00})
    begin
      errors++;
      $display("FAIL abort_outputs got %b_%b_%h_%h_%b_%b exp 1_0_00_00_0_0",
               cpuReset, memEnable, memAdr, memWD, rxReady, done);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({cpuReset, memEnable, rxReady} !== 3'b100) begin
        errors++;
        $display("FAIL abort_hold%0d got cpuReset=%b memEnable=%b rxReady=%b exp 1 0 0",
                 i, cpuReset, memEnable, rxReady);
      end
    end
    checks++;
    if (wr_cnt != wr0) begin
      errors++;
      $display("FAIL abort_no_write got %0d exp %0d", wr_cnt, wr0);
    end
    rxValid = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (rxReady !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got rxReady=%b exp 0", rxReady);
    end
    @(negedge clk);
    checks++;
    if (rxReady !== 1'b1) begin
      errors++;
      $display("FAIL abort_waitlen got rxReady=%b exp 1", rxReady);
    end
    rxData = 8'h01;
    rxValid = 1'b1;
    @(negedge clk);
    rxData = 8'h5C;
    @(negedge clk);
    rxValid = 1'b0;
    checks++;
    if ({memEnable, memAdr, memWD} !== {1'b1, 8'h00, 8'h5C}) begin
      errors++;
      $display("FAIL abort_reload_wr got %b %h %h exp 1 00 5c", memEnable, memAdr, memWD);
    end
    @(negedge clk);
    checks++;
    if ({done, cpuReset} !== 2'b10) begin
      errors++;
      $display("FAIL abort_reload_run got done=%b cpuReset=%b exp 1 0", done, cpuReset);
    end
    @(negedge clk);
    checks++;
    if ((wr_cnt - wr0) != 1) begin
      errors++;
      $display("FAIL abort_reload_count got %0d exp 1", wr_cnt - wr0);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_len256();
    test_stall();
    test_cpu_passthrough();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
